// File: rtl/i2c_target.sv
// Single-address I2C target. Samples SCL/SDA via 2-FF synchronisers, detects
// START/STOP, matches a fixed 7-bit address, ACKs, and exchanges bytes with
// local logic through a wr_valid / rd_req handshake. Drives SDA low or
// releases it; never stretches SCL.
module i2c_target #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  inout  wire        sda_io,
  output logic       wr_valid_o,
  output logic [7:0] wr_data_o,
  output logic       rd_req_o,
  input  logic [7:0] rd_data_i,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

  state_e      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_sr;
  logic [7:0]  tx_sr;
  logic        byte_done;  // full byte / ACK seen, act on the next SCL fall
  logic        addr_hit;
  logic        rw_read;
  logic        sda_oe;     // 1 = pull SDA low

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;
  logic sda_in;

  // Open-drain: only ever low or high-impedance.
  assign sda_io = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda_io;

  // Bring the asynchronous bus lines into clk_i and keep one previous sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: synchroniser flops reset to 1 (idle bus level) so that leaving
      // reset on an idle bus never looks like a START or an SCL edge.
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the old value
      // of its predecessor, which is what turns this into a real FF chain.
      scl_meta <= scl_i;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda_in;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  logic scl_rise, scl_fall, bus_start, bus_stop;
  assign scl_rise  =  scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync &  scl_prev;
  assign bus_start =  scl_sync &  scl_prev &  sda_prev & ~sda_sync;
  assign bus_stop  =  scl_sync &  scl_prev & ~sda_prev &  sda_sync;

  // Protocol FSM with all outputs and the SDA drive registered.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shift_sr   <= 8'h00;
      tx_sr      <= 8'h00;
      byte_done  <= 1'b0;
      addr_hit   <= 1'b0;
      rw_read    <= 1'b0;
      sda_oe     <= 1'b0;
      wr_valid_o <= 1'b0;
      wr_data_o  <= 8'h00;
      rd_req_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      wr_valid_o <= 1'b0;
      rd_req_o   <= 1'b0;
      done_o     <= 1'b0;

      if (bus_start) begin
        // Repeated START is treated exactly like a fresh START.
        state     <= ST_ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        addr_hit  <= 1'b0;
        sda_oe    <= 1'b0;
        busy_o    <= 1'b0;
      end else if (bus_stop) begin
        state     <= ST_IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        done_o    <= busy_o;
        busy_o    <= 1'b0;
      end else begin
        case (state)
          ST_ADDR: begin
            if (scl_rise) begin
              shift_sr <= {shift_sr[6:0], sda_sync};
              if (bit_cnt == 3'd0) begin
                byte_done <= 1'b1;
                // Incoming bit is R/W; the address is the 7 bits already held.
                if (shift_sr[6:0] == ADDR) begin
                  addr_hit <= 1'b1;
                  busy_o   <= 1'b1;
                  rw_read  <= sda_sync;
                  rd_req_o <= sda_sync;
                end else begin
                  addr_hit <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (addr_hit) begin
                sda_oe <= 1'b1;
                state  <= ST_ADDR_ACK;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_IGNORE;
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd7;
              if (rw_read) begin
                tx_sr  <= rd_data_i;
                sda_oe <= ~rd_data_i[7];
                state  <= ST_RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_WR_DATA;
              end
            end
          end

          ST_WR_DATA: begin
            if (scl_rise) begin
              shift_sr <= {shift_sr[6:0], sda_sync};
              if (bit_cnt == 3'd0) begin
                wr_data_o  <= {shift_sr[6:0], sda_sync};
                wr_valid_o <= 1'b1;
                byte_done  <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 3'd1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= ST_WR_ACK;
            end
          end

          ST_WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd7;
              state   <= ST_WR_DATA;
            end
          end

          ST_RD_DATA: begin
            // bit_cnt counts bits still to be placed after the one on the bus.
            if (scl_fall) begin
              if (bit_cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= ST_RD_ACK;
              end else begin
                tx_sr   <= {tx_sr[6:0], 1'b0};
                sda_oe  <= ~tx_sr[6];
                bit_cnt <= bit_cnt - 3'd1;
              end
            end
          end

          ST_RD_ACK: begin
            if (scl_rise) begin
              if (!sda_sync) begin
                rd_req_o  <= 1'b1;
                byte_done <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= ST_IGNORE;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              tx_sr     <= rd_data_i;
              sda_oe    <= ~rd_data_i[7];
              bit_cnt   <= 3'd7;
              state     <= ST_RD_DATA;
            end
          end

          ST_IGNORE: begin
            sda_oe <= 1'b0;
          end

          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
